sigma_32: RTL and testbench

- Pipelined 32-input summation block for the MLP feed-forward datapath.
- Adds 32 signed-magnitude fixed-point words (1 sign bit, 14 integer bits, 17 fraction bits) and returns one saturated signed-magnitude sum.
- Used as the neuron accumulation stage after the multipliers.
- Single clock; asynchronous active-low reset.

---
 rtl/nn_pkg.sv | 52 +++++
 rtl/sm_to_tc.sv | 16 +
 rtl/sigma_32.sv | 86 ++++++++
 tb/tb_sigma_32.sv | 139 +++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg: shared types, constants and number-format helpers for the MLP
// feed-forward datapath.
//   word_t  : signed-magnitude word (bit W-1 = sign, W-2..0 = magnitude)
//   acc_t   : two's complement accumulator, wide enough for N full-scale
//             addends without overflow
//   sm_to_tc      : signed-magnitude word -> accumulator value
//   tc_to_sm_sat  : accumulator value -> saturated signed-magnitude word
// ---------------------------------------------------------------------------
package nn_pkg;

  localparam int N     = 32;
  localparam int W     = 32;
  localparam int FRAC  = 17;
  localparam int ACC_W = W + $clog2(N);

  typedef logic [W-1:0]             word_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef struct packed {
    word_t c;
    logic  ovf;
  } sm_res_t;

  // Largest magnitude representable in a word: 2^(W-1)-1.
  localparam acc_t MAG_MAX = acc_t'({{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}});

  // Negative zero negates a zero magnitude, so it lands on 0 naturally.
  function automatic acc_t sm_to_tc(input word_t w);
    acc_t mag;
    mag = acc_t'({{(ACC_W-W+1){1'b0}}, w[W-2:0]});
    return w[W-1] ? -mag : mag;
  endfunction

  // A zero sum has a clear sign bit, so negative zero is never produced.
  function automatic sm_res_t tc_to_sm_sat(input acc_t s);
    sm_res_t res;
    logic    neg;
    acc_t    mag;
    neg = s[ACC_W-1];
    mag = neg ? -s : s;
    if (mag > MAG_MAX) begin
      res.c   = {neg, MAG_MAX[W-2:0]};
      res.ovf = 1'b1;
    end else begin
      res.c   = {neg, mag[W-2:0]};
      res.ovf = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sm_to_tc.sv
// ---------------------------------------------------------------------------
// sm_to_tc: combinational conversion of one signed-magnitude addend into the
// two's complement accumulator format.
//   w : signed-magnitude input word
//   v : two's complement value (ACC_W bits)
// ---------------------------------------------------------------------------
module sm_to_tc
  import nn_pkg::*;
(
  input  logic [W-1:0]            w,
  output logic signed [ACC_W-1:0] v
);

  assign v = nn_pkg::sm_to_tc(w);

endmodule

// File: rtl/sigma_32.sv
// ---------------------------------------------------------------------------
// sigma_32: pipelined 32-input signed-magnitude summation with saturation.
// Two-cycle latency, one set per cycle, no backpressure.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : addend set a is valid this cycle
//   a         : 32 signed-magnitude addends, a[i][0] is addend i
//   out_valid : c/ovf valid this cycle
//   c         : saturated signed-magnitude sum (holds last valid result)
//   ovf       : sum magnitude exceeded 2^31-1 and was saturated
// ---------------------------------------------------------------------------
module sigma_32
  import nn_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a [0:31][1],
  output logic        out_valid,
  output logic [31:0] c,
  output logic        ovf
);

  acc_t    conv_p0 [N];
  acc_t    part_p1 [N/2];
  logic    vld_p1;
  acc_t    lvl8    [8];
  acc_t    lvl4    [4];
  acc_t    lvl2    [2];
  acc_t    sum_p1;
  sm_res_t res_p1;
  word_t   c_p2;
  logic    ovf_p2;
  logic    vld_p2;

  // ---- stage 0: signed-magnitude -> two's complement ----
  for (genvar i = 0; i < N; i++) begin : g_cvt
    sm_to_tc u_cvt (
      .w (a[i][0]),
      .v (conv_p0[i])
    );
  end

  // ---- stage 1: pairwise partial sums ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      for (int i = 0; i < N/2; i++) part_p1[i] <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < N/2; i++)
          part_p1[i] <= conv_p0[2*i] + conv_p0[2*i+1];
      end
    end
  end

  // Balanced 4-level reduction of the 16 partials; 37 bits cannot overflow.
  always_comb begin
    for (int i = 0; i < 8; i++) lvl8[i] = part_p1[2*i] + part_p1[2*i+1];
    for (int i = 0; i < 4; i++) lvl4[i] = lvl8[2*i] + lvl8[2*i+1];
    for (int i = 0; i < 2; i++) lvl2[i] = lvl4[2*i] + lvl4[2*i+1];
    sum_p1 = lvl2[0] + lvl2[1];
    res_p1 = tc_to_sm_sat(sum_p1);
  end

  // ---- stage 2: reduced, saturated signed-magnitude result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      c_p2   <= '0;
      ovf_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        c_p2   <= res_p1.c;
        ovf_p2 <= res_p1.ovf;
      end
    end
  end

  assign out_valid = vld_p2;
  assign c         = c_p2;
  assign ovf       = ovf_p2;

endmodule

// File: tb/tb_sigma_32.sv
// ---------------------------------------------------------------------------
// tb_sigma_32: directed self-checking bench for sigma_32.
// ---------------------------------------------------------------------------
module tb_sigma_32;

  localparam logic [31:0] PI     = 32'h0006487E;
  localparam logic [31:0] NEG_PI = 32'h8006487E;
  localparam logic [31:0] E      = 32'h00056FC2;
  localparam logic [31:0] NEG_E  = 32'h80056FC2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a [0:31][1];
  logic        out_valid;
  logic [31:0] c;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;

  sigma_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .out_valid (out_valid),
    .c         (c),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic set_all(input logic [31:0] w);
    for (int i = 0; i < 32; i++) a[i][0] = w;
  endtask

  // One-cycle in_valid pulse; checks exact 2-cycle latency and the result.
  task automatic run_vec(input string tag, input logic [31:0] exp_c, input logic exp_ovf);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_vld1"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_vld2"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_c"},    c, exp_c);
    chk({tag, "_ovf"},  {31'b0, ovf}, {31'b0, exp_ovf});
    @(posedge clk); #1;
    chk({tag, "_vld3"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    set_all(32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", {31'b0, out_valid}, 32'd0);
    chk("rst_c",   c, 32'h0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_all(PI);
    run_vec("all_pi", 32'h00C90FC0, 1'b0);
    chk("hold_c", c, 32'h00C90FC0);

    for (int i = 0; i < 32; i++) a[i][0] = (i < 16) ? PI : NEG_PI;
    run_vec("pi_cancel", 32'h00000000, 1'b0);

    set_all(32'h80000000);
    run_vec("neg_zero", 32'h00000000, 1'b0);

    set_all(32'h7FFFFFFF);
    run_vec("sat_pos", 32'h7FFFFFFF, 1'b1);

    set_all(32'hFFFFFFFF);
    run_vec("sat_neg", 32'hFFFFFFFF, 1'b1);

    set_all(32'h0);
    a[0][0] = PI;
    a[1][0] = E;
    run_vec("pi_plus_e", 32'h000BB840, 1'b0);
    a[1][0] = NEG_E;
    run_vec("pi_minus_e", 32'h0000D8BC, 1'b0);

    // Back-to-back stream.
    set_all(PI);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_all(32'h0);
    @(posedge clk); #1;
    chk("strm0_vld", {31'b0, out_valid}, 32'd1);
    chk("strm0_c",   c, 32'h00C90FC0);
    set_all(NEG_PI);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("strm1_vld", {31'b0, out_valid}, 32'd1);
    chk("strm1_c",   c, 32'h00000000);
    @(posedge clk); #1;
    chk("strm2_vld", {31'b0, out_valid}, 32'd1);
    chk("strm2_c",   c, 32'h80C90FC0);
    chk("strm2_ovf", {31'b0, ovf}, 32'd0);
    @(posedge clk); #1;
    chk("strm_end_vld", {31'b0, out_valid}, 32'd0);
    chk("strm_hold_c",  c, 32'h80C90FC0);

    // Reset while a set is in flight.
    set_all(PI);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_c",   c, 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_vld2", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_vld", {31'b0, out_valid}, 32'd0);
    chk("post_rst_c",   c, 32'h0);
    set_all(PI);
    run_vec("after_rst", 32'h00C90FC0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
